// File: rtl/pgr_uart_pkg.sv
// Shared encodings, FSM state type and helper functions for the parametrised
// UART transmitter of the uart2apb bridge.
package pgr_uart_pkg;

  // Parity type field encodings
  localparam logic [1:0] PAR_EVEN  = 2'b00;
  localparam logic [1:0] PAR_ODD   = 2'b01;
  localparam logic [1:0] PAR_SPACE = 2'b10;
  localparam logic [1:0] PAR_MARK  = 2'b11;

  // Stop length field encodings (2'b11 behaves as two stop bits as well)
  localparam logic [1:0] STOP_1    = 2'b00;
  localparam logic [1:0] STOP_1P5  = 2'b01;
  localparam logic [1:0] STOP_2    = 2'b10;

  // Width of the tick counter; large enough for two stop bits at OVERSAMPLE=16
  localparam int unsigned CNT_W = 6;

  // Transmitter FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } tx_state_e;

  // Number of clk_en ticks spent in the stop phase for a given stop field.
  // OVERSAMPLE is even, so the 1.5 stop case is exact.
  function automatic logic [CNT_W-1:0] stop_ticks(input logic [1:0]       stop_len,
                                                  input logic [CNT_W-1:0] os);
    logic [CNT_W-1:0] ticks;
    case (stop_len)
      STOP_1:   ticks = os;
      STOP_1P5: ticks = os + (os >> 1);
      STOP_2:   ticks = os << 1;
      default:  ticks = os << 1;
    endcase
    return ticks;
  endfunction

  // Parity bit over the lowest n bits of data; bits at or above n do not
  // contribute, so stale upper FIFO bits can never disturb the parity.
  function automatic logic parity_bit(input logic [15:0] data,
                                      input logic [3:0]  n,
                                      input logic [1:0]  ptype);
    logic acc;
    logic par;
    acc = 1'b0;
    for (int unsigned i = 32'd0; i < 32'd16; i++) begin
      if (4'(i) < n) begin
        acc = acc ^ data[4'(i)];
      end else begin
        acc = acc;
      end
    end
    case (ptype)
      PAR_EVEN:  par = acc;
      PAR_ODD:   par = ~acc;
      PAR_SPACE: par = 1'b0;
      PAR_MARK:  par = 1'b1;
      default:   par = 1'b1;
    endcase
    return par;
  endfunction

endpackage

// File: rtl/pgr_uart_sync2.sv
// Two-flop synchroniser for the asynchronous active-low CTS input.
// Resets to 1 so the line reads "not clear to send" until proven otherwise.
module pgr_uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage resynchronisation of d into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/pgr_uart_tx_gen.sv
// Parametrised UART transmitter. Drains a show-ahead TX FIFO and serialises
// each word onto txd with per-frame latched configuration, optional parity
// (even/odd/space/mark), 1/1.5/2 stop bits, CTS flow control and break.
module pgr_uart_tx_gen
  import pgr_uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 6,
  parameter int unsigned DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic [DATA_W-1:0] tx_fifo_rd_data,
  input  logic              tx_fifo_rd_data_valid,
  output logic              tx_fifo_rd_data_req,
  input  logic [2:0]        uart_word_len,
  input  logic              uart_parity_en,
  input  logic [1:0]        uart_parity_type,
  input  logic [1:0]        uart_stop_len,
  input  logic              uart_mode,
  input  logic              cts_en,
  input  logic              cts_n,
  input  logic              tx_break,
  output logic              txd,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam logic [CNT_W-1:0] OS_TICKS = CNT_W'(OVERSAMPLE);
  localparam logic [CNT_W-1:0] OS_LAST  = OS_TICKS - 6'd1;
  localparam logic [3:0]       DW_BITS  = 4'(DATA_W);

  // FSM and counters
  tx_state_e        state_r;
  logic [CNT_W-1:0] tick_cnt_r;
  logic [3:0]       bit_cnt_r;
  logic             brk_rel_r;

  // Per-frame latched word and configuration
  logic [DATA_W-1:0] data_r;
  logic [3:0]        n_r;
  logic              par_en_r;
  logic [1:0]        ptype_r;
  logic [1:0]        stop_r;
  logic              mode_r;

  // Registered outputs
  logic txd_r;
  logic req_r;
  logic busy_r;
  logic done_r;

  // Combinational helpers
  logic             cts_sync_s;
  logic [3:0]       wl_sum_s;
  logic [3:0]       n_sel_s;
  logic [3:0]       bit_sel_s;
  logic [3:0]       bit_idx_s;
  logic [15:0]      data_ext_s;
  logic             bit_val_s;
  logic             par_s;
  logic [CNT_W-1:0] stop_last_s;
  logic             launch_ok_s;

  pgr_uart_sync2 u_cts_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cts_n),
    .q     (cts_sync_s)
  );

  // Effective word length for the next frame: 5 + field, clamped to DATA_W
  always_comb begin
    wl_sum_s = {1'b0, uart_word_len} + 4'd5;
    n_sel_s  = 4'd0;
    if (wl_sum_s > DW_BITS) begin
      n_sel_s = DW_BITS;
    end else begin
      n_sel_s = wl_sum_s;
    end
  end

  // Bit selection mux: data bit to drive on the next bit boundary, picked by
  // the bit counter in the latched order (no shifted copy of the word kept)
  always_comb begin
    bit_sel_s = 4'd0;
    bit_idx_s = 4'd0;
    if (state_r == ST_DATA) begin
      bit_sel_s = bit_cnt_r + 4'd1;
    end else begin
      bit_sel_s = 4'd0;
    end
    if (mode_r) begin
      bit_idx_s = n_r - 4'd1 - bit_sel_s;
    end else begin
      bit_idx_s = bit_sel_s;
    end
    data_ext_s = 16'(data_r);
    bit_val_s  = data_ext_s[bit_idx_s];
  end

  // Parity, stop length and launch qualification from latched/current state
  always_comb begin
    par_s       = parity_bit(16'(data_r), n_r, ptype_r);
    stop_last_s = stop_ticks(stop_r, OS_TICKS) - 6'd1;
    launch_ok_s = tx_fifo_rd_data_valid && (!cts_en || !cts_sync_s);
  end

  // Transmit FSM: frame sequencing, per-frame latching and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      tick_cnt_r <= 6'd0;
      bit_cnt_r  <= 4'd0;
      brk_rel_r  <= 1'b0;
      data_r     <= '0;
      n_r        <= 4'd0;
      par_en_r   <= 1'b0;
      ptype_r    <= 2'b00;
      stop_r     <= 2'b00;
      mode_r     <= 1'b0;
      txd_r      <= 1'b1;
      req_r      <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      req_r  <= 1'b0;
      done_r <= 1'b0;
      if (clk_en) begin
        case (state_r)
          ST_IDLE: begin
            tick_cnt_r <= 6'd0;
            bit_cnt_r  <= 4'd0;
            if (tx_break) begin
              state_r   <= ST_BREAK;
              brk_rel_r <= 1'b0;
              txd_r     <= 1'b0;
              busy_r    <= 1'b1;
            end else if (launch_ok_s) begin
              state_r  <= ST_START;
              data_r   <= tx_fifo_rd_data;
              n_r      <= n_sel_s;
              par_en_r <= uart_parity_en;
              ptype_r  <= uart_parity_type;
              stop_r   <= uart_stop_len;
              mode_r   <= uart_mode;
              req_r    <= 1'b1;
              txd_r    <= 1'b0;
              busy_r   <= 1'b1;
            end else begin
              txd_r  <= 1'b1;
              busy_r <= 1'b0;
            end
          end

          ST_START: begin
            if (tick_cnt_r == OS_LAST) begin
              tick_cnt_r <= 6'd0;
              state_r    <= ST_DATA;
              txd_r      <= bit_val_s;
            end else begin
              tick_cnt_r <= tick_cnt_r + 6'd1;
            end
          end

          ST_DATA: begin
            if (tick_cnt_r == OS_LAST) begin
              tick_cnt_r <= 6'd0;
              if (bit_cnt_r == n_r - 4'd1) begin
                bit_cnt_r <= 4'd0;
                if (par_en_r) begin
                  state_r <= ST_PARITY;
                  txd_r   <= par_s;
                end else begin
                  state_r <= ST_STOP;
                  txd_r   <= 1'b1;
                end
              end else begin
                bit_cnt_r <= bit_cnt_r + 4'd1;
                txd_r     <= bit_val_s;
              end
            end else begin
              tick_cnt_r <= tick_cnt_r + 6'd1;
            end
          end

          ST_PARITY: begin
            if (tick_cnt_r == OS_LAST) begin
              tick_cnt_r <= 6'd0;
              state_r    <= ST_STOP;
              txd_r      <= 1'b1;
            end else begin
              tick_cnt_r <= tick_cnt_r + 6'd1;
            end
          end

          ST_STOP: begin
            // The tick counter spans the whole stop period here
            if (tick_cnt_r == stop_last_s) begin
              tick_cnt_r <= 6'd0;
              state_r    <= ST_IDLE;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
            end else begin
              tick_cnt_r <= tick_cnt_r + 6'd1;
            end
          end

          ST_BREAK: begin
            if (!brk_rel_r) begin
              // Line held low until the request drops, then one mark bit
              if (!tx_break) begin
                brk_rel_r  <= 1'b1;
                tick_cnt_r <= 6'd0;
                txd_r      <= 1'b1;
              end else begin
                txd_r <= 1'b0;
              end
            end else if (tick_cnt_r == OS_LAST) begin
              tick_cnt_r <= 6'd0;
              brk_rel_r  <= 1'b0;
              state_r    <= ST_IDLE;
              busy_r     <= 1'b0;
            end else begin
              tick_cnt_r <= tick_cnt_r + 6'd1;
            end
          end

          default: begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= 6'd0;
            bit_cnt_r  <= 4'd0;
            brk_rel_r  <= 1'b0;
            txd_r      <= 1'b1;
            busy_r     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign txd                 = txd_r;
  assign tx_fifo_rd_data_req = req_r;
  assign tx_busy             = busy_r;
  assign tx_done             = done_r;

endmodule

// File: tb/tb_pgr_uart_tx_gen.sv
// Self-checking bench for pgr_uart_tx_gen (OVERSAMPLE=6, DATA_W=8).
// Expected line levels come from a frame model built from the UART framing
// rules (start, data in chosen order, parity, stop length).
module tb_pgr_uart_tx_gen;

  localparam int OS = 6;
  localparam int DW = 8;

  logic       clk;
  logic       rst_n;
  logic       clk_en;
  logic [7:0] tx_fifo_rd_data;
  logic       tx_fifo_rd_data_valid;
  logic       tx_fifo_rd_data_req;
  logic [2:0] uart_word_len;
  logic       uart_parity_en;
  logic [1:0] uart_parity_type;
  logic [1:0] uart_stop_len;
  logic       uart_mode;
  logic       cts_en;
  logic       cts_n;
  logic       tx_break;
  logic       txd;
  logic       tx_busy;
  logic       tx_done;

  int passed;
  int failed;
  int total;
  int req_cnt;
  int overlap_cnt;
  int wr_ptr;
  int rd_ptr;
  logic [7:0] fifo_mem [0:63];

  pgr_uart_tx_gen #(.OVERSAMPLE(OS), .DATA_W(DW)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .clk_en                (clk_en),
    .tx_fifo_rd_data       (tx_fifo_rd_data),
    .tx_fifo_rd_data_valid (tx_fifo_rd_data_valid),
    .tx_fifo_rd_data_req   (tx_fifo_rd_data_req),
    .uart_word_len         (uart_word_len),
    .uart_parity_en        (uart_parity_en),
    .uart_parity_type      (uart_parity_type),
    .uart_stop_len         (uart_stop_len),
    .uart_mode             (uart_mode),
    .cts_en                (cts_en),
    .cts_n                 (cts_n),
    .tx_break              (tx_break),
    .txd                   (txd),
    .tx_busy               (tx_busy),
    .tx_done               (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Oversample tick: random spacing, roughly one in three clk cycles
  initial begin
    clk_en = 1'b0;
    forever begin
      @(negedge clk);
      clk_en = ($urandom_range(0, 2) == 0);
    end
  end

  // Show-ahead FIFO model plus req / done monitors
  initial begin
    tx_fifo_rd_data       = 8'h00;
    tx_fifo_rd_data_valid = 1'b0;
    req_cnt               = 0;
    overlap_cnt           = 0;
    rd_ptr                = 0;
    forever begin
      @(negedge clk);
      if (tx_fifo_rd_data_req === 1'b1) begin
        req_cnt++;
        if (rd_ptr != wr_ptr) rd_ptr++;
      end
      if (tx_fifo_rd_data_req === 1'b1 && tx_done === 1'b1) overlap_cnt++;
      tx_fifo_rd_data_valid = (rd_ptr != wr_ptr);
      tx_fifo_rd_data       = (rd_ptr != wr_ptr) ? fifo_mem[rd_ptr % 64] : 8'h00;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick();
    int g;
    g = 0;
    @(posedge clk);
    while (clk_en !== 1'b1 && g < 200) begin
      @(posedge clk);
      g++;
    end
    if (g >= 200) check("tick_timeout", 32'd0, 32'd1);
    #1;
  endtask

  task automatic push(input logic [7:0] w);
    fifo_mem[wr_ptr % 64] = w;
    wr_ptr++;
  endtask

  task automatic set_cfg(input logic [2:0] wl, input logic pen, input logic [1:0] pt,
                         input logic [1:0] sl, input logic md);
    uart_word_len    = wl;
    uart_parity_en   = pen;
    uart_parity_type = pt;
    uart_stop_len    = sl;
    uart_mode        = md;
  endtask

  // Waits for the frame launch (or demands it on the very next tick when b2b)
  // and then compares txd on every tick against the modelled frame.
  task automatic check_frame(input string tag, input logic [7:0] w, input logic [2:0] wl,
                             input logic pen, input logic [1:0] pt, input logic [1:0] sl,
                             input logic md, input logic b2b);
    logic       lv[$];
    logic       bits[$];
    logic [7:0] masked;
    logic       par;
    int         n;
    int         ones;
    int         stop_t;
    int         waited;
    n = 5 + int'(wl);
    if (n > DW) n = DW;
    masked = 8'(int'(w) % (1 << n));
    ones   = $countones(masked);
    for (int i = 0; i < n; i++) begin
      if (md) bits.push_front(masked[i]);
      else    bits.push_back(masked[i]);
    end
    case (pt)
      2'b00:   par = (ones % 2 == 1);
      2'b01:   par = (ones % 2 == 0);
      2'b10:   par = 1'b0;
      default: par = 1'b1;
    endcase
    if (sl == 2'b00)      stop_t = OS;
    else if (sl == 2'b01) stop_t = OS + OS / 2;
    else                  stop_t = 2 * OS;
    repeat (OS) lv.push_back(1'b0);
    foreach (bits[i]) repeat (OS) lv.push_back(bits[i]);
    if (pen) repeat (OS) lv.push_back(par);
    repeat (stop_t) lv.push_back(1'b1);

    if (b2b) begin
      wait_tick();
      check({tag, "_b2b_req"}, 32'(tx_fifo_rd_data_req), 32'd1);
    end else begin
      waited = 0;
      while (tx_fifo_rd_data_req !== 1'b1 && waited < 3000) begin
        @(posedge clk);
        #1;
        waited++;
      end
      check({tag, "_req"}, 32'(tx_fifo_rd_data_req), 32'd1);
    end
    if (tx_fifo_rd_data_req !== 1'b1) return;
    check({tag, "_busy"}, 32'(tx_busy), 32'd1);
    for (int k = 0; k < lv.size(); k++) begin
      if (k > 0) wait_tick();
      check({tag, "_txd"}, 32'(txd), 32'(lv[k]));
      check({tag, "_nodone"}, 32'(tx_done), 32'd0);
    end
    wait_tick();
    check({tag, "_done"}, 32'(tx_done), 32'd1);
    check({tag, "_idle_txd"}, 32'(txd), 32'd1);
    check({tag, "_idle_busy"}, 32'(tx_busy), 32'd0);
  endtask

  initial begin
    int base;
    int waited;
    logic [7:0] rw;
    passed   = 0;
    failed   = 0;
    total    = 0;
    wr_ptr   = 0;
    rst_n    = 1'b0;
    cts_en   = 1'b0;
    cts_n    = 1'b1;
    tx_break = 1'b0;
    set_cfg(3'd3, 1'b0, 2'b00, 2'b00, 1'b0);

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_req", 32'(tx_fifo_rd_data_req), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) wait_tick();
    check("idle_txd", 32'(txd), 32'd1);
    check("idle_noreq", 32'(req_cnt), 32'd0);

    // 8N1 LSB first, 0x55
    push(8'h55);
    check_frame("f8n1", 8'h55, 3'd3, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

    // 7 bits, odd parity, 1.5 stop, MSB first, 0x41
    set_cfg(3'd2, 1'b1, 2'b01, 2'b01, 1'b1);
    push(8'h41);
    check_frame("f7o15", 8'h41, 3'd2, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0);

    // Word length field above DATA_W-5 clamps; mark parity, 2 stop
    set_cfg(3'd7, 1'b1, 2'b11, 2'b10, 1'b0);
    push(8'hA5);
    check_frame("fclamp", 8'hA5, 3'd7, 1'b1, 2'b11, 2'b10, 1'b0, 1'b0);

    // 5 bits even parity: upper bits ignored in data and parity
    set_cfg(3'd0, 1'b1, 2'b00, 2'b00, 1'b0);
    push(8'hE3);
    check_frame("f5e", 8'hE3, 3'd0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);

    // CTS flow control
    set_cfg(3'd3, 1'b0, 2'b00, 2'b00, 1'b0);
    cts_en = 1'b1;
    cts_n  = 1'b1;
    base   = req_cnt;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    repeat (30) wait_tick();
    check("cts_hold_req", 32'(req_cnt - base), 32'd0);
    check("cts_hold_txd", 32'(txd), 32'd1);
    cts_n = 1'b0;
    check_frame("cts_f1", 8'h11, 3'd3, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    fork
      check_frame("cts_f2", 8'h22, 3'd3, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
      begin
        repeat (20) wait_tick();
        cts_n = 1'b1;
      end
    join
    repeat (40) wait_tick();
    check("cts_f3_held", 32'(req_cnt - base), 32'd2);
    check("cts_f3_txd", 32'(txd), 32'd1);
    check("cts_f3_busy", 32'(tx_busy), 32'd0);
    cts_n = 1'b0;
    check_frame("cts_f3", 8'h33, 3'd3, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    cts_en = 1'b0;
    cts_n  = 1'b1;

    // Break raised mid-frame
    push(8'h5A);
    push(8'hC3);
    fork
      check_frame("brk_f1", 8'h5A, 3'd3, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
      begin
        repeat (15) wait_tick();
        tx_break = 1'b1;
      end
    join
    base = req_cnt;
    wait_tick();
    check("brk_enter_txd", 32'(txd), 32'd0);
    check("brk_enter_busy", 32'(tx_busy), 32'd1);
    repeat (20) begin
      wait_tick();
      check("brk_low", 32'(txd), 32'd0);
    end
    tx_break = 1'b0;
    wait_tick();
    check("brk_rel_txd", 32'(txd), 32'd1);
    for (int k = 1; k <= 5; k++) begin
      wait_tick();
      check("brk_mark_txd", 32'(txd), 32'd1);
      check("brk_mark_busy", 32'(tx_busy), 32'd1);
    end
    wait_tick();
    check("brk_exit_busy", 32'(tx_busy), 32'd0);
    check("brk_exit_txd", 32'(txd), 32'd1);
    check("brk_no_pop", 32'(req_cnt - base), 32'd0);
    check_frame("brk_f2", 8'hC3, 3'd3, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);

    // Configuration change mid-frame only affects the next frame
    set_cfg(3'd3, 1'b1, 2'b00, 2'b00, 1'b0);
    push(8'h96);
    fork
      check_frame("cfg_cur", 8'h96, 3'd3, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
      begin
        repeat (12) wait_tick();
        set_cfg(3'd0, 1'b0, 2'b00, 2'b10, 1'b1);
      end
    join
    push(8'h3C);
    check_frame("cfg_next", 8'h3C, 3'd0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0);

    // Asynchronous reset mid-frame
    set_cfg(3'd3, 1'b0, 2'b00, 2'b00, 1'b0);
    push(8'h81);
    push(8'h7E);
    waited = 0;
    while (tx_fifo_rd_data_req !== 1'b1 && waited < 3000) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("rstm_launch", 32'(tx_fifo_rd_data_req), 32'd1);
    repeat (20) wait_tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstm_txd", 32'(txd), 32'd1);
    check("rstm_busy", 32'(tx_busy), 32'd0);
    check("rstm_req", 32'(tx_fifo_rd_data_req), 32'd0);
    base = req_cnt;
    repeat (10) @(negedge clk);
    check("rstm_no_pop", 32'(req_cnt - base), 32'd0);
    rst_n = 1'b1;
    check_frame("rstm_head", 8'h7E, 3'd3, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

    // Randomised frames
    for (int r = 0; r < 10; r++) begin
      logic [2:0] wl;
      logic       pen;
      logic [1:0] pt;
      logic [1:0] sl;
      logic       md;
      rw  = 8'($urandom);
      wl  = 3'($urandom_range(0, 7));
      pen = 1'($urandom_range(0, 1));
      pt  = 2'($urandom_range(0, 3));
      sl  = 2'($urandom_range(0, 3));
      md  = 1'($urandom_range(0, 1));
      set_cfg(wl, pen, pt, sl, md);
      push(rw);
      check_frame("rnd", rw, wl, pen, pt, sl, md, 1'b0);
    end

    check("all_words_popped", 32'(req_cnt), 32'(wr_ptr));
    check("done_req_exclusive", 32'(overlap_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
